// File: rtl/prog_data_mem_pkg.sv
// prog_data_mem_pkg
// Shared definitions for the program/data store:
//   - state_t     : load/run FSM state encoding (also exported on dbg_state)
//   - DEF_*       : default geometry (8-bit words, 4-bit address, 16 words)
//   - even_parity : parity bit that makes {parity, data} have an even number
//                   of ones; used only when MEM_PARITY_EN is defined.
package prog_data_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  // Callers zero-extend their word to 64 bits; zero bits do not change the XOR.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array_1r1w.sv
// mem_array_1r1w
// Plain synchronous array with one write port and one registered read port.
// A read and a write to the same word in one cycle return the old word
// (read-before-write). The storage and the read register have no reset;
// the read register only updates when i_re is high.
// Ports:
//   clk      : clock
//   i_we     : write enable, i_waddr/i_wdata committed at the edge
//   i_waddr  : write address (must be < DEPTH when i_we is high)
//   i_wdata  : write data
//   i_re     : read enable, o_rdata loads mem[i_raddr] at the edge
//   i_raddr  : read address (must be < DEPTH when i_re is high)
//   o_rdata  : registered read data, held while i_re is low
module mem_array_1r1w #(
  parameter int W      = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);

  logic [W-1:0] r_mem [0:DEPTH-1];
  logic [W-1:0] r_rdata;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_data_mem.sv
// prog_data_mem
// Clocked program/data store shared by the controller/PC/MAR path and the
// accumulator. After reset a load FSM either fills the array from a word
// stream (load_mode=1) or goes straight to RUN (load_mode=0). In RUN the CPU
// reads (1-cycle latency) and writes through separate synchronous ports.
//
// Optional feature, macro MEM_PARITY_EN: each word carries an even-parity
// bit computed on load and on write; a read whose recomputed parity differs
// raises par_err together with rd_valid. Without the macro there is no
// parity storage and no par_err port.
//
// Load handshake: in LOAD, load_ready is high and a word transfers on every
// rising edge where load_valid && load_ready; load_valid may be held or
// dropped at any time and load_data only matters on transfer edges.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   load_mode             : request load; falling in LOAD ends a partial load
//   load_valid/load_data  : load stream, written at the load counter
//   load_ready            : high in LOAD
//   load_done             : one-cycle pulse in DONE
//   busy                  : high whenever the FSM is not in RUN
//   rd_en/rd_addr         : read request (RUN only)
//   rd_data/rd_valid      : registered read result, rd_data held between reads
//   wr_en/wr_addr/wr_data : write request (RUN only)
//   addr_err              : pulse for an accepted access with address >= DEPTH
//   par_err               : (MEM_PARITY_EN) parity mismatch on the returned word
//   dbg_state             : current FSM state (state_t encoding)
module prog_data_mem
  import prog_data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH   // 1 <= DEPTH <= 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              addr_err,
`ifdef MEM_PARITY_EN
  output logic              par_err,
`endif
  output logic [1:0]        dbg_state
);

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;

  logic                r_rd_valid;
  logic                r_rd_zero;   // last result was out of range, or no read since reset
  logic                r_addr_err;

  logic                w_load_hs;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_rd_oob;
  logic                w_wr_oob;
  logic                w_we;
  logic                w_re;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [MEM_W-1:0]    w_wword;
  logic [MEM_W-1:0]    w_rword;

  // Accesses are qualified with !rst so nothing lands in the array on a reset edge.
  assign w_load_hs = (r_state == ST_LOAD) && load_valid && !rst;
  assign w_rd_acc  = (r_state == ST_RUN) && rd_en && !rst;
  assign w_wr_acc  = (r_state == ST_RUN) && wr_en && !rst;
  assign w_rd_oob  = {1'b0, rd_addr} >= DEPTH_V;
  assign w_wr_oob  = {1'b0, wr_addr} >= DEPTH_V;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = load_mode ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        if (w_load_hs) w_cnt_nxt = r_cnt + 1'b1;
        // A word handed over in the same cycle load_mode falls is still written.
        if ((w_load_hs && (r_cnt == LAST_ADDR)) || !load_mode) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (load_mode) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign load_ready = (r_state == ST_LOAD);
  assign load_done  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_RUN);
  assign dbg_state  = r_state;

  // ---------------- array ----------------
  // Load and CPU writes never overlap: the load port is live only in LOAD,
  // the CPU port only in RUN.
  assign w_we    = w_load_hs || (w_wr_acc && !w_wr_oob);
  assign w_waddr = w_load_hs ? r_cnt : wr_addr;
  assign w_wdata = w_load_hs ? load_data : wr_data;
  assign w_re    = w_rd_acc && !w_rd_oob;

`ifdef MEM_PARITY_EN
  // Parity helper takes 64 bits; DATA_W is expected to stay within that.
  assign w_wword = {even_parity(64'(w_wdata)), w_wdata};
`else
  assign w_wword = w_wdata;
`endif

  mem_array_1r1w #(
    .W      (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_arr (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wword),
    .i_re    (w_re),
    .i_raddr (rd_addr),
    .o_rdata (w_rword)
  );

  // ---------------- read/status registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_zero  <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_zero <= w_rd_oob;
      // Read error lines up with rd_valid; write error lands one cycle after wr_en.
      r_addr_err <= (w_rd_acc && w_rd_oob) || (w_wr_acc && w_wr_oob);
    end
  end

  // The array's read register holds between reads, so rd_data holds too;
  // the zero flag covers both reset and out-of-range reads.
  assign rd_data  = r_rd_zero ? '0 : w_rword[DATA_W-1:0];
  assign rd_valid = r_rd_valid;
  assign addr_err = r_addr_err;

`ifdef MEM_PARITY_EN
  assign par_err = r_rd_valid && !r_rd_zero &&
                   (w_rword[DATA_W] != even_parity(64'(w_rword[DATA_W-1:0])));
`endif

endmodule
